// File: rtl/stream_fbw_pkg.sv
// Shared definitions for the byte-stream frame-buffer writer: FSM state
// encoding, statistics counter width and a saturating adder for the drop count.
package stream_fbw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_STORE = 2'd2,
    ST_FRAME = 2'd3
  } fbw_state_t;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [STAT_W-1:0] b);
    logic [STAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/stream_fbw_writer.sv
// Byte-per-pixel stream to HUB75 frame-buffer write port.
// Packs accepted bytes into rows, commits each full row with a one-cycle
// store/swap pulse, then holds a frame swap request until the driver accepts.
// A start-of-frame byte arriving mid-frame aborts the frame and restarts at
// (0,0); the bytes already written in the aborted frame count as drops.
// Optional: define STREAM_HFLIP_EN to mirror the written column address.
//
// state | meaning
// IDLE  | waiting for a start-of-frame byte, other bytes dropped
// FILL  | writing pixels of the current row
// STORE | row full, waiting for fbw_row_rdy to commit it
// FRAME | all rows committed, frame_swap held until frame_rdy
module stream_fbw_writer
  import stream_fbw_pkg::*;
#(
  parameter  int N_ROWS     = 64,
  parameter  int N_COLS     = 64,
  parameter  int BITDEPTH   = 8,
  localparam int LOG_N_ROWS = $clog2(N_ROWS),
  localparam int LOG_N_COLS = $clog2(N_COLS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BITDEPTH-1:0]   s_data,
  input  logic                  s_sof,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [LOG_N_ROWS-1:0] fbw_row_addr,
  output logic [BITDEPTH-1:0]   fbw_data,
  output logic [LOG_N_COLS-1:0] fbw_col_addr,
  output logic                  fbw_wren,
  output logic                  fbw_row_store,
  input  logic                  fbw_row_rdy,
  output logic                  fbw_row_swap,
  output logic                  frame_swap,
  input  logic                  frame_rdy,
  output logic [STAT_W-1:0]     stat_frames,
  output logic [STAT_W-1:0]     stat_drops
);

  fbw_state_t              r_state;
  fbw_state_t              w_state_nxt;
  logic                    r_live;
  logic                    r_arm;
  logic [LOG_N_ROWS-1:0]   r_row;
  logic [LOG_N_COLS-1:0]   r_col;
  logic                    r_wren;
  logic [BITDEPTH-1:0]     r_wdata;
  logic [LOG_N_COLS-1:0]   r_wcol;
  logic [STAT_W-1:0]       r_frames;
  logic [STAT_W-1:0]       r_drops;

  logic                    w_ready;
  logic                    w_accept;
  logic                    w_last_col;
  logic                    w_last_row;
  logic                    w_write;
  logic                    w_restart;
  logic                    w_resync;
  logic                    w_drop_one;
  logic                    w_store;
  logic                    w_frame_done;
  logic [LOG_N_COLS-1:0]   w_col_idx;
  logic [LOG_N_COLS-1:0]   w_wcol;
  logic [STAT_W-1:0]       w_aborted;

  // r_live keeps s_ready low until the first edge after reset release
  assign w_ready    = r_live & ((r_state == ST_IDLE) | (r_state == ST_FILL));
  assign w_accept   = s_valid & w_ready;
  assign w_last_col = (r_col == LOG_N_COLS'(N_COLS - 1));
  assign w_last_row = (r_row == LOG_N_ROWS'(N_ROWS - 1));
  assign w_col_idx  = w_restart ? '0 : r_col;
  // bytes already written in the current frame, charged as drops on resync
  assign w_aborted  = STAT_W'(r_row) * STAT_W'(N_COLS) + STAT_W'(r_col);

`ifdef STREAM_HFLIP_EN
  assign w_wcol = LOG_N_COLS'(N_COLS - 1) - w_col_idx;
`else
  assign w_wcol = w_col_idx;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state decode and per-cycle control strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_write      = 1'b0;
    w_restart    = 1'b0;
    w_resync     = 1'b0;
    w_drop_one   = 1'b0;
    w_store      = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (s_sof) begin
            w_write     = 1'b1;
            w_restart   = 1'b1;
            w_state_nxt = ST_FILL;
          end else begin
            w_drop_one  = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (w_accept) begin
          w_write = 1'b1;
          if (s_sof) begin
            w_restart = 1'b1;
            w_resync  = 1'b1;
          end else if (w_last_col) begin
            w_state_nxt = ST_STORE;
          end
        end
      end
      ST_STORE: begin
        // r_arm skips the first STORE cycle so the commit trails the last write
        if (r_arm && fbw_row_rdy) begin
          w_store     = 1'b1;
          w_state_nxt = w_last_row ? ST_FRAME : ST_FILL;
        end
      end
      ST_FRAME: begin
        if (frame_rdy) begin
          w_frame_done = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // row/column counters, registered write port and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live   <= 1'b0;
      r_arm    <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_wren   <= 1'b0;
      r_wdata  <= '0;
      r_wcol   <= '0;
      r_frames <= '0;
      r_drops  <= '0;
    end else begin
      r_live <= 1'b1;
      r_arm  <= (r_state == ST_STORE);
      r_wren <= w_write;
      if (w_write) begin
        r_wdata <= s_data;
        r_wcol  <= w_wcol;
        if (w_restart)       r_col <= LOG_N_COLS'(1);
        else if (w_last_col) r_col <= '0;
        else                 r_col <= r_col + LOG_N_COLS'(1);
      end
      if (w_restart || w_frame_done)  r_row <= '0;
      else if (w_store && !w_last_row) r_row <= r_row + LOG_N_ROWS'(1);
      if (w_frame_done) r_frames <= r_frames + STAT_W'(1);
      if (w_drop_one)    r_drops <= sat_add(r_drops, STAT_W'(1));
      else if (w_resync) r_drops <= sat_add(r_drops, w_aborted);
    end
  end

  assign s_ready       = w_ready;
  assign fbw_row_addr  = r_row;
  assign fbw_data      = r_wdata;
  assign fbw_col_addr  = r_wcol;
  assign fbw_wren      = r_wren;
  assign fbw_row_store = w_store;
  assign fbw_row_swap  = w_store;
  assign frame_swap    = (r_state == ST_FRAME);
  assign stat_frames   = r_frames;
  assign stat_drops    = r_drops;

endmodule
